// File: rtl/fp_cmp_pkg.sv
// Shared codes and helpers for the pipelined FloPoCo floating-point comparator.
package fp_cmp_pkg;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [2:0] CMP_EQ    = 3'd0;
  localparam logic [2:0] CMP_NE    = 3'd1;
  localparam logic [2:0] CMP_LT    = 3'd2;
  localparam logic [2:0] CMP_LE    = 3'd3;
  localparam logic [2:0] CMP_GT    = 3'd4;
  localparam logic [2:0] CMP_GE    = 3'd5;
  localparam logic [2:0] CMP_UNORD = 3'd6;
  localparam logic [2:0] CMP_ORD   = 3'd7;

  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_cmp_key.sv
// Normalises one FloPoCo operand into flags plus an unsigned magnitude key.
module fp_cmp_key
  import fp_cmp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 21
) (
  input  logic [WE+WF+2:0] op,
  output logic             nan,
  output logic             zero,
  output logic             sign,
  output logic [WE+WF+1:0] key
);

  logic [1:0] exc;

  assign exc  = op[WE+WF+2:WE+WF+1];
  assign sign = op[WE+WF];
  assign nan  = (exc == EXC_NAN);
  assign zero = (exc == EXC_ZERO);

  // Exponent/fraction of zero and inf are junk; clear them so equal classes compare equal.
  always_comb begin
    key = {exc, {(WE+WF){1'b0}}};
    if (exc == EXC_NORMAL || exc == EXC_NAN)
      key = {exc, op[WE+WF-1:0]};
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined eight-predicate FloPoCo comparator with IEEE-style unordered handling.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int  WE           = 11,
  parameter int  WF           = 21,
  parameter int  TAG_W        = 4,
  parameter int  EXTRA_STAGES = 0,
  localparam int W            = fp_width(WE, WF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic [2:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic             result,
  output logic             unordered,
  output logic [TAG_W-1:0] out_tag
);

  logic             nan_a, zero_a, sign_a;
  logic             nan_b, zero_b, sign_b;
  logic [W-2:0]     key_a, key_b;

  fp_cmp_key #(.WE(WE), .WF(WF)) u_key_a (
    .op(inA), .nan(nan_a), .zero(zero_a), .sign(sign_a), .key(key_a)
  );
  fp_cmp_key #(.WE(WE), .WF(WF)) u_key_b (
    .op(inB), .nan(nan_b), .zero(zero_b), .sign(sign_b), .key(key_b)
  );

  logic             v1, gt1, eq1, sa1, sb1, bz1, nana1, nanb1;
  logic [2:0]       mode1;
  logic [TAG_W-1:0] tag1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      gt1   <= 1'b0;
      eq1   <= 1'b0;
      sa1   <= 1'b0;
      sb1   <= 1'b0;
      bz1   <= 1'b0;
      nana1 <= 1'b0;
      nanb1 <= 1'b0;
      mode1 <= '0;
      tag1  <= '0;
    end else begin
      v1    <= in_valid;
      gt1   <= (key_a > key_b);
      eq1   <= (key_a == key_b);
      sa1   <= sign_a;
      sb1   <= sign_b;
      bz1   <= zero_a & zero_b;
      nana1 <= nan_a;
      nanb1 <= nan_b;
      mode1 <= mode;
      tag1  <= in_tag;
    end
  end

  logic s_lt, s_eq, s_gt, unord, pred;

  always_comb begin
    s_lt  = 1'b0;
    s_eq  = 1'b0;
    s_gt  = 1'b0;
    unord = nana1 | nanb1;
    if (bz1) begin
      s_eq = 1'b1;
    end else if (sa1 != sb1) begin
      s_lt = sa1;
      s_gt = sb1;
    end else if (!sa1) begin
      s_gt = gt1;
      s_eq = eq1;
      s_lt = !gt1 && !eq1;
    end else begin
      // Both negative: larger magnitude is the smaller value.
      s_lt = gt1;
      s_eq = eq1;
      s_gt = !gt1 && !eq1;
    end

    pred = 1'b0;
    case (mode1)
      CMP_EQ:    pred = !unord && s_eq;
      CMP_NE:    pred = unord || !s_eq;
      CMP_LT:    pred = !unord && s_lt;
      CMP_LE:    pred = !unord && (s_lt || s_eq);
      CMP_GT:    pred = !unord && s_gt;
      CMP_GE:    pred = !unord && (s_gt || s_eq);
      CMP_UNORD: pred = unord;
      CMP_ORD:   pred = !unord;
      default:   pred = 1'b0;
    endcase
  end

  // Index 0 is the stage-2 register; higher indices are the optional delay stages.
  logic [EXTRA_STAGES:0] v_p, r_p, u_p;
  logic [TAG_W-1:0]      t_p [EXTRA_STAGES+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_p <= '0;
      r_p <= '0;
      u_p <= '0;
      for (int i = 0; i <= EXTRA_STAGES; i++)
        t_p[i] <= '0;
    end else begin
      v_p[0] <= v1;
      r_p[0] <= v1 & pred;
      u_p[0] <= v1 & unord;
      if (v1)
        t_p[0] <= tag1;
      for (int i = 1; i <= EXTRA_STAGES; i++) begin
        v_p[i] <= v_p[i-1];
        r_p[i] <= r_p[i-1];
        u_p[i] <= u_p[i-1];
        if (v_p[i-1])
          t_p[i] <= t_p[i-1];
      end
    end
  end

  assign out_valid = v_p[EXTRA_STAGES];
  assign result    = r_p[EXTRA_STAGES];
  assign unordered = u_p[EXTRA_STAGES];
  assign out_tag   = t_p[EXTRA_STAGES];

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench: directed table, latency/burst/reset sequences and random vs a real-valued model.
module tb_fp_compare_pipe;
  import fp_cmp_pkg::*;

  localparam int WE    = 11;
  localparam int WF    = 21;
  localparam int TAG_W = 4;
  localparam int W     = WE + WF + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     inA, inB;
  logic [2:0]       mode;
  logic [TAG_W-1:0] in_tag;

  logic             ov0, r0, u0;
  logic [TAG_W-1:0] t0;
  logic             ov3, r3, u3;
  logic [TAG_W-1:0] t3;

  fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TAG_W), .EXTRA_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inA(inA), .inB(inB), .mode(mode),
    .in_tag(in_tag), .out_valid(ov0), .result(r0), .unordered(u0), .out_tag(t0)
  );

  fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TAG_W), .EXTRA_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inA(inA), .inB(inB), .mode(mode),
    .in_tag(in_tag), .out_valid(ov3), .result(r3), .unordered(u3), .out_tag(t3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic cur_res, cur_un;

  typedef struct {
    logic             res;
    logic             un;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2:0]       m;
    logic [TAG_W-1:0] tag;
    logic             res;
    logic             un;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] x, input logic s,
                                      input logic [WE-1:0] e, input logic [WF-1:0] f);
    return {x, s, e, f};
  endfunction

  // Real-valued view of an operand: zero is 0, normals ordered by exp then frac, inf is huge.
  function automatic real fval(input logic [W-1:0] op);
    logic [1:0] x;
    real        m;
    x = op[W-1:W-2];
    case (x)
      2'b00:   m = 0.0;
      2'b01:   m = 1.0 + real'(op[WE+WF-1:WF]) + real'(op[WF-1:0]) / (2.0 ** WF);
      default: m = 1.0e9;
    endcase
    return op[W-3] ? -m : m;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                       output logic res, output logic un);
    real va, vb;
    un  = (a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11);
    va  = fval(a);
    vb  = fval(b);
    res = 1'b0;
    if (un) res = (m == CMP_NE) || (m == CMP_UNORD);
    else case (m)
      CMP_EQ:  res = (va == vb);
      CMP_NE:  res = (va != vb);
      CMP_LT:  res = (va <  vb);
      CMP_LE:  res = (va <= vb);
      CMP_GT:  res = (va >  vb);
      CMP_GE:  res = (va >= vb);
      CMP_ORD: res = 1'b1;
      default: res = 1'b0;
    endcase
  endtask

  function automatic logic [W-1:0] rand_op();
    int          k;
    logic [1:0]  x;
    logic [WE-1:0] e;
    logic [WF-1:0] f;
    k = $urandom_range(0, 9);
    x = (k == 0) ? 2'b00 : (k <= 6) ? 2'b01 : (k <= 8) ? 2'b10 : 2'b11;
    e = ($urandom_range(0, 1) == 1) ? WE'(1023 + $urandom_range(0, 2)) : WE'($urandom);
    f = ($urandom_range(0, 1) == 1) ? WF'($urandom_range(0, 3)) : WF'($urandom);
    return {x, 1'($urandom_range(0, 1)), e, f};
  endfunction

  // Monitor: check outputs then record any transaction issued this cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q0.delete();
      q3.delete();
      chk("dut0 outputs in reset", {ov0, r0, u0, t0}, 0);
      chk("dut3 outputs in reset", {ov3, r3, u3, t3}, 0);
    end else begin
      if (ov0) begin
        chk("dut0 result pending on out_valid", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("dut0 latency", cyc - e.cyc, 2);
          chk("dut0 result", r0, e.res);
          chk("dut0 unordered", u0, e.un);
          chk("dut0 out_tag", t0, e.tag);
        end
      end else begin
        chk("dut0 idle result/unordered", {r0, u0}, 0);
        chk("dut0 missing out_valid", (q0.size() > 0) && (q0[0].cyc + 2 <= cyc), 0);
      end
      if (ov3) begin
        chk("dut3 result pending on out_valid", q3.size() > 0, 1);
        if (q3.size() > 0) begin
          e = q3.pop_front();
          chk("dut3 latency", cyc - e.cyc, 5);
          chk("dut3 result", r3, e.res);
          chk("dut3 unordered", u3, e.un);
          chk("dut3 out_tag", t3, e.tag);
        end
      end else begin
        chk("dut3 idle result/unordered", {r3, u3}, 0);
        chk("dut3 missing out_valid", (q3.size() > 0) && (q3[0].cyc + 5 <= cyc), 0);
      end
      if (in_valid) begin
        e.res = cur_res;
        e.un  = cur_un;
        e.tag = in_tag;
        e.cyc = cyc;
        q0.push_back(e);
        q3.push_back(e);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                       input logic [TAG_W-1:0] tag, input logic res, input logic un);
    @(posedge clk);
    #1;
    inA      = a;
    inB      = b;
    mode     = m;
    in_tag   = tag;
    cur_res  = res;
    cur_un   = un;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inA      = W'($urandom);
      inB      = W'($urandom);
    end
  endtask

  task automatic issue_rand(input logic [TAG_W-1:0] tag);
    logic [W-1:0] a, b;
    logic [2:0]   m;
    logic         res, un;
    a = rand_op();
    b = ($urandom_range(0, 3) == 0) ? a : rand_op();
    m = 3'($urandom_range(0, 7));
    model(a, b, m, res, un);
    issue(a, b, m, tag, res, un);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[17];
    logic [W-1:0] p1, p2, n1, n2, pz, nz, nan_op, pinf, ninf;

    p1     = mk(2'b01, 1'b0, 11'h3FF, 21'h0);
    p2     = mk(2'b01, 1'b0, 11'h400, 21'h0);
    n1     = mk(2'b01, 1'b1, 11'h3FF, 21'h0);
    n2     = mk(2'b01, 1'b1, 11'h400, 21'h0);
    pz     = mk(2'b00, 1'b0, 11'h1AB, 21'h12345);
    nz     = mk(2'b00, 1'b1, 11'h000, 21'h0);
    nan_op = mk(2'b11, 1'b0, 11'h3FF, 21'h1);
    pinf   = mk(2'b10, 1'b0, 11'h5A5, 21'h0ABCD);
    ninf   = mk(2'b10, 1'b1, 11'h7FF, 21'h1FFFF);

    tbl[0]  = '{p1, p2, CMP_LT, 4'd5, 1'b1, 1'b0};
    tbl[1]  = '{pz, nz, CMP_EQ, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{pz, nz, CMP_LT, 4'd2, 1'b0, 1'b0};
    tbl[3]  = '{nan_op, p1, CMP_EQ,    4'd8,  1'b0, 1'b1};
    tbl[4]  = '{nan_op, p1, CMP_NE,    4'd9,  1'b1, 1'b1};
    tbl[5]  = '{nan_op, p1, CMP_LT,    4'd10, 1'b0, 1'b1};
    tbl[6]  = '{nan_op, p1, CMP_LE,    4'd11, 1'b0, 1'b1};
    tbl[7]  = '{nan_op, p1, CMP_GT,    4'd12, 1'b0, 1'b1};
    tbl[8]  = '{nan_op, p1, CMP_GE,    4'd13, 1'b0, 1'b1};
    tbl[9]  = '{nan_op, p1, CMP_UNORD, 4'd14, 1'b1, 1'b1};
    tbl[10] = '{nan_op, p1, CMP_ORD,   4'd15, 1'b0, 1'b1};
    tbl[11] = '{ninf, n1, CMP_LT, 4'd3, 1'b1, 1'b0};
    tbl[12] = '{n2,   n1, CMP_GE, 4'd4, 1'b0, 1'b0};
    tbl[13] = '{pinf, mk(2'b10, 1'b0, 11'h0, 21'h0), CMP_LE, 4'd6, 1'b1, 1'b0};
    tbl[14] = '{p2,   p1, CMP_GT, 4'd7, 1'b1, 1'b0};
    tbl[15] = '{n1,   pz, CMP_LT, 4'd0, 1'b1, 1'b0};
    tbl[16] = '{p1, nan_op, CMP_ORD, 4'd2, 1'b0, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    inA      = '0;
    inB      = '0;
    mode     = '0;
    in_tag   = '0;
    cur_res  = 1'b0;
    cur_un   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Isolated transaction: exact latency on both pipelines.
    issue(tbl[0].a, tbl[0].b, tbl[0].m, tbl[0].tag, tbl[0].res, tbl[0].un);
    idle(8);

    // Whole table back to back.
    for (int i = 0; i < 17; i++)
      issue(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].tag, tbl[i].res, tbl[i].un);
    idle(8);

    // Continuous 8-deep burst.
    for (int i = 0; i < 8; i++)
      issue_rand(4'(i + 3));
    idle(8);

    // Reset mid-burst: in-flight work is dropped.
    for (int i = 0; i < 4; i++)
      issue_rand(4'(i + 9));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("dut0 outputs at reset assertion", {ov0, r0, u0, t0}, 0);
    chk("dut3 outputs at reset assertion", {ov3, r3, u3, t3}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    issue(p1, p2, CMP_GE, 4'hA, 1'b0, 1'b0);
    idle(8);

    // Random traffic with random gaps.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0) issue_rand(4'($urandom));
      else idle(1);
    end
    idle(10);

    chk("dut0 queue drained", q0.size(), 0);
    chk("dut3 queue drained", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined floating-point comparator for FloPoCo-format operands: 2-bit exception field, sign, WE-bit exponent, WF-bit fraction.
- Successor to the single-predicate compare used in the ray/AABB slab test. Compares operands directly (no subtractor), so the result does not depend on subtractor latency.
- Selects one of eight predicates per transaction and gives IEEE-style unordered (NaN) handling.
- Adds a valid/tag pipeline so one compare per cycle can issue with fixed latency.

Parameters:
- WE, 11, exponent width
- WF, 21, fraction width
- TAG_W, 4, width of the opaque tag carried alongside each compare
- EXTRA_STAGES, 0, extra output register stages (0..4) for timing closure
- Derived: W = WE+WF+3 (operand width); LATENCY = 2+EXTRA_STAGES

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/mode/tag valid this cycle
- inA  in  W  operand A, FloPoCo format
- inB  in  W  operand B, FloPoCo format
- mode  in  3  predicate select
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- result  out  1  predicate value
- unordered  out  1  either operand NaN
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all valid bits, result, unordered and out_tag go to 0, including every pipeline stage. A transaction in flight when reset asserts is discarded; no out_valid follows.
- Handshake: no backpressure. Every cycle with in_valid=1 is accepted. out_valid=1 exactly LATENCY cycles later, in order. Back-to-back issue gives back-to-back results.
- When out_valid=0, result and unordered are driven 0; out_tag holds its last value.
- Exception field decode: 00 zero, 01 normal, 10 inf, 11 NaN.
- Stage 1 (registered), classify each operand:
  - NaN flag.
  - Magnitude key = {exc, exp, frac}, with exp/frac forced 0 when exc is 00 or 10.
  - Key ordering therefore gives zero < normal < inf.
  - Register: magA>magB, magA==magB, signs, both-zero flag, NaN flags, mode, tag, valid.
- Stage 2 (registered), signed relation:
  - If both operands are zero: EQ, regardless of sign (+0 == -0).
  - Else if signs differ: the negative operand is smaller.
  - Else if both positive: the magnitude relation.
  - Else (both negative): the inverted magnitude relation.
- Mode encoding:
  - 000 EQ, 001 NE, 010 LT (A<B), 011 LE, 100 GT, 101 GE, 110 UNORD, 111 ORD.
- If either operand is NaN:
  - unordered=1.
  - EQ/LT/LE/GT/GE give 0; NE gives 1; UNORD gives 1; ORD gives 0.
- Infinities compare as ordinary extremes: +inf == +inf, and -inf < any normal.
- EXTRA_STAGES: pure delay of {valid, result, unordered, tag}, reset like the other stages.
- The exp/frac of zero, inf and NaN encodings are don't-care and must never affect result.

Decomposition:
- Package fp_cmp_pkg holds:
  - Exception codes EXC_ZERO/NORMAL/INF/NAN.
  - Mode codes CMP_EQ..CMP_ORD as 3-bit localparams.
  - A function computing W from WE/WF.
- One sub-module, fp_cmp_key: combinational; normalises one operand to {nan, zero, sign, key}. Instantiated twice in stage 1.

Test Plan:
- Default params, EXTRA_STAGES=0:
  - +1.0 (exc=01, s=0, e=0x3FF, f=0) vs +2.0 (e=0x400), mode LT, tag 5 -> out_valid exactly 2 cycles later, result=1, unordered=0, out_tag=5.
  - +0 (exc=00, s=0, junk exp/frac 0x1AB/0x12345) vs -0 (exc=00, s=1), mode EQ -> result=1; same pair in mode LT -> result=0.
  - NaN (exc=11) vs +1.0, each mode 000..111 on consecutive cycles -> results 0,1,0,0,0,0,1,0, all with unordered=1, in issue order.
  - -inf vs -1.0 mode LT -> 1; -2.0 vs -1.0 mode GE -> 0; +inf vs +inf mode LE -> 1.
- EXTRA_STAGES=3: 8-cycle continuous in_valid burst -> 8 results beginning cycle 5, correct tags, no gaps.
- Assert rst during that burst -> all outputs 0 the same cycle; no out_valid after release until new input.
